// File: rtl/agc_pkg.sv
// Shared types and defaults for the AGC symbol controller.
// Holds the FSM state encoding and the symbol/slot geometry.
package agc_pkg;

  localparam int BEATS         = 32;
  localparam int MAX_OUTST     = 2;
  localparam int SYMB_PER_SLOT = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/beat_cnt.sv
// Loadable-depth wrap counter with terminal-count flag.
// Counts inc pulses and wraps to 0 on the beat where cnt == depth-1.
module beat_cnt #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] depth,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == depth - W'(1));

  always_ff @(posedge i_clk) begin
    if (i_reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/agc_symb_ctrl.sv
// Symbol framing and in-flight flow control for the AGC unpack path.
// Gates upstream beats, marks symbol/slot ends, tracks symbols in flight.
module agc_symb_ctrl #(
  parameter int BEATS         = agc_pkg::BEATS,
  parameter int MAX_OUTST     = agc_pkg::MAX_OUTST,
  parameter int SYMB_PER_SLOT = agc_pkg::SYMB_PER_SLOT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cfg_en,
  input  logic [5:0] i_cfg_beats,
  input  logic       i_rvalid,
  input  logic       i_rlast,
  input  logic       i_tx_vld,
  output logic       o_rready,
  output logic       o_rvalid,
  output logic       o_symb_eop,
  output logic [3:0] o_symb_idx,
  output logic       o_slot_eop,
  output logic [1:0] o_outst,
  output logic       o_err_len,
  output logic       o_busy
);

  import agc_pkg::state_t;
  import agc_pkg::ST_IDLE;
  import agc_pkg::ST_RUN;
  import agc_pkg::ST_DRAIN;
  import agc_pkg::ST_ERR;

  state_t     state_q, state_d;
  logic [5:0] depth_q;
  logic [5:0] in_cnt, out_cnt;
  logic       in_tc, out_tc;
  logic       xfer, eop, len_err, bound;
  logic       out_inc, out_done, start;

  assign xfer     = i_rvalid && o_rready;
  assign eop      = xfer && in_tc;
  assign len_err  = xfer && (i_rlast != in_tc);
  // Safe to stop only between symbols, incl. on the closing beat
  assign bound    = (in_cnt == 6'd0 && !xfer) || eop;
  assign out_inc  = i_tx_vld && (o_outst != 2'd0);
  assign out_done = out_inc && out_tc;
  assign start    = (state_q == ST_IDLE) && i_cfg_en;

  beat_cnt #(.W(6)) u_in_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clr     (state_q != ST_RUN),
    .inc     (xfer),
    .depth   (depth_q),
    .cnt     (in_cnt),
    .tc      (in_tc)
  );

  beat_cnt #(.W(6)) u_out_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clr     (state_q == ST_IDLE),
    .inc     (out_inc),
    .depth   (depth_q),
    .cnt     (out_cnt),
    .tc      (out_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_cfg_en) state_d = ST_RUN;
      ST_RUN: begin
        if (len_err)                state_d = ST_ERR;
        else if (!i_cfg_en && bound) state_d = ST_DRAIN;
      end
      ST_ERR:   state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (o_outst == 2'd0 && out_cnt == 6'd0)
          state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rready = !i_reset && (state_q == ST_RUN)
               && (o_outst < 2'(MAX_OUTST));
    o_busy   = !i_reset && (state_q != ST_IDLE);
  end

  assign o_rvalid   = xfer;
  assign o_symb_eop = eop;
  assign o_slot_eop = eop
                      && (o_symb_idx == 4'(SYMB_PER_SLOT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      depth_q    <= 6'(BEATS);
      o_symb_idx <= 4'd0;
      o_outst    <= 2'd0;
      o_err_len  <= 1'b0;
    end else begin
      if (start) begin
        depth_q    <= (i_cfg_beats == 6'd0) ? 6'(BEATS)
                                            : i_cfg_beats;
        o_symb_idx <= 4'd0;
        o_err_len  <= 1'b0;
      end else begin
        if (len_err) o_err_len <= 1'b1;
        if (eop) begin
          o_symb_idx <= o_slot_eop ? 4'd0
                                   : o_symb_idx + 4'd1;
        end
      end
      unique case ({eop, out_done})
        2'b10:   o_outst <= o_outst + 2'd1;
        2'b01:   o_outst <= o_outst - 2'd1;
        default: o_outst <= o_outst;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_symb_ctrl.sv
// Directed self-checking bench for agc_symb_ctrl.
// Each task drives one scenario and checks hand-derived values.
module tb_agc_symb_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_cfg_en = 1'b0;
  logic [5:0] i_cfg_beats = 6'd0;
  logic       i_rvalid = 1'b0;
  logic       i_rlast = 1'b0;
  logic       i_tx_vld = 1'b0;
  logic       o_rready, o_rvalid, o_symb_eop, o_slot_eop;
  logic [3:0] o_symb_idx;
  logic [1:0] o_outst;
  logic       o_err_len, o_busy;

  int checks = 0;
  int errors = 0;
  logic c_eop, c_slot, c_rready, c_rvalid;

  agc_symb_ctrl dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_cfg_en    (i_cfg_en),
    .i_cfg_beats (i_cfg_beats),
    .i_rvalid    (i_rvalid),
    .i_rlast     (i_rlast),
    .i_tx_vld    (i_tx_vld),
    .o_rready    (o_rready),
    .o_rvalid    (o_rvalid),
    .o_symb_eop  (o_symb_eop),
    .o_symb_idx  (o_symb_idx),
    .o_slot_eop  (o_slot_eop),
    .o_outst     (o_outst),
    .o_err_len   (o_err_len),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Drive one cycle; capture comb outputs mid-cycle, return 1ns after edge
  task automatic cycle(input logic rv, input logic rl, input logic tx);
    i_rvalid = rv;
    i_rlast  = rl;
    i_tx_vld = tx;
    #2;
    c_eop    = o_symb_eop;
    c_slot   = o_slot_eop;
    c_rready = o_rready;
    c_rvalid = o_rvalid;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_wait(output int n);
    n = 0;
    while (o_busy && n < 200) begin
      cycle(1'b0, 1'b0, 1'b1);
      n++;
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (c_rready !== 1'b0 || c_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rdy got %b%b exp 00", c_rready, c_rvalid);
    end
    checks++;
    if ({o_busy, o_outst, o_symb_idx, o_err_len} !== 8'd0) begin
      errors++;
      $display("FAIL rst_regs got %b exp 0",
               {o_busy, o_outst, o_symb_idx, o_err_len});
    end
    i_reset = 1'b0;
  endtask

  task automatic test_slot;
    int neop, slot_at, lows, n;
    neop = 0; slot_at = 0; lows = 0;
    i_cfg_en = 1'b1;
    i_cfg_beats = 6'd0;
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (o_busy !== 1'b1 || o_rready !== 1'b1) begin
      errors++;
      $display("FAIL run_entry got %b%b exp 11", o_busy, o_rready);
    end
    for (int b = 0; b < 448; b++) begin
      cycle(1'b1, (b % 32) == 31, 1'b1);
      if (!c_rready) lows++;
      if (c_eop) begin
        neop++;
        if (c_slot) slot_at = neop;
        checks++;
        if (o_symb_idx !== 4'(neop % 14) || o_outst !== 2'd1) begin
          errors++;
          $display("FAIL eop_idx got %0d/%0d exp %0d/1",
                   o_symb_idx, o_outst, neop % 14);
        end
      end
    end
    checks++;
    if (neop != 14 || slot_at != 14 || lows != 0) begin
      errors++;
      $display("FAIL slot got eops %0d slot %0d lows %0d exp 14 14 0",
               neop, slot_at, lows);
    end
    for (int b = 0; b < 32; b++) cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (o_outst !== 2'd0) begin
      errors++;
      $display("FAIL slot_drain got %0d exp 0", o_outst);
    end
    i_cfg_en = 1'b0;
    idle_wait(n);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL slot_idle got %b exp 0", o_busy);
    end
  endtask

  task automatic test_backpressure;
    int n;
    i_cfg_en = 1'b1;
    i_cfg_beats = 6'd0;
    cycle(1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 64; b++) cycle(1'b1, (b % 32) == 31, 1'b0);
    checks++;
    if (o_outst !== 2'd2 || o_rready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got %0d/%b exp 2/0", o_outst, o_rready);
    end
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (c_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_gate got %b exp 0", c_rvalid);
    end
    for (int b = 0; b < 32; b++) cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if (o_outst !== 2'd1 || o_rready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got %0d/%b exp 1/1", o_outst, o_rready);
    end
    i_cfg_en = 1'b0;
    idle_wait(n);
    checks++;
    if (o_busy !== 1'b0 || o_outst !== 2'd0) begin
      errors++;
      $display("FAIL bp_idle got %b/%0d exp 0/0", o_busy, o_outst);
    end
  endtask

  task automatic test_cfg_depth;
    logic [7:0] mask;
    int n;
    mask = '0;
    i_cfg_en = 1'b1;
    i_cfg_beats = 6'd4;
    cycle(1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      cycle(1'b1, (b % 4) == 3, 1'b0);
      mask[b] = c_eop;
    end
    checks++;
    if (mask !== 8'b1000_1000 || o_symb_idx !== 4'd2) begin
      errors++;
      $display("FAIL depth4 got %b/%0d exp 10001000/2", mask, o_symb_idx);
    end
    i_cfg_en = 1'b0;
    idle_wait(n);
    checks++;
    if (o_busy !== 1'b0 || n != 9) begin
      errors++;
      $display("FAIL depth4_drain got %b/%0d exp 0/9", o_busy, n);
    end
  endtask

  task automatic test_len_err;
    i_cfg_en = 1'b1;
    i_cfg_beats = 6'd0;
    cycle(1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 20; b++) cycle(1'b1, 1'b0, 1'b0);
    i_cfg_en = 1'b0;
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (c_eop !== 1'b0 || o_err_len !== 1'b1) begin
      errors++;
      $display("FAIL err_set got %b/%b exp 0/1", c_eop, o_err_len);
    end
    checks++;
    if (o_rready !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL err_state got %b/%b exp 0/1", o_rready, o_busy);
    end
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (c_rready !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL err_drain got %b/%b exp 0/1", c_rready, o_busy);
    end
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (o_busy !== 1'b0 || o_err_len !== 1'b1) begin
      errors++;
      $display("FAIL err_idle got %b/%b exp 0/1", o_busy, o_err_len);
    end
    i_cfg_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (o_err_len !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got %b/%b exp 0/1", o_err_len, o_busy);
    end
    i_cfg_en = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    int first, n;
    first = -1;
    i_cfg_en = 1'b1;
    i_cfg_beats = 6'd0;
    cycle(1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 10; b++) cycle(1'b1, 1'b0, 1'b0);
    i_reset = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (c_eop !== 1'b0 || c_rready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_out got %b/%b exp 0/0", c_eop, c_rready);
    end
    checks++;
    if ({o_busy, o_outst, o_symb_idx, o_err_len, o_rready} !== 9'd0) begin
      errors++;
      $display("FAIL mid_rst_regs got %b exp 0",
               {o_busy, o_outst, o_symb_idx, o_err_len, o_rready});
    end
    i_reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 32; b++) begin
      cycle(1'b1, b == 31, 1'b0);
      if (c_eop && first < 0) first = b;
    end
    checks++;
    if (first != 31) begin
      errors++;
      $display("FAIL mid_rst_eop got %0d exp 31", first);
    end
    i_cfg_en = 1'b0;
    idle_wait(n);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_idle got %b exp 0", o_busy);
    end
  endtask

  task automatic test_cfg_drop;
    int lows, n;
    logic last_eop;
    lows = 0;
    i_cfg_en = 1'b1;
    i_cfg_beats = 6'd0;
    cycle(1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 10; b++) cycle(1'b1, 1'b0, 1'b0);
    i_cfg_en = 1'b0;
    for (int b = 10; b < 32; b++) begin
      cycle(1'b1, b == 31, 1'b0);
      if (!c_rready) lows++;
    end
    last_eop = c_eop;
    checks++;
    if (lows != 0 || last_eop !== 1'b1) begin
      errors++;
      $display("FAIL drop_run got lows %0d eop %b exp 0 1", lows, last_eop);
    end
    checks++;
    if (o_rready !== 1'b0 || o_busy !== 1'b1 || o_outst !== 2'd1) begin
      errors++;
      $display("FAIL drop_drain got %b/%b/%0d exp 0/1/1",
               o_rready, o_busy, o_outst);
    end
    idle_wait(n);
    checks++;
    if (o_busy !== 1'b0 || o_outst !== 2'd0 || n != 33) begin
      errors++;
      $display("FAIL drop_idle got %b/%0d/%0d exp 0/0/33",
               o_busy, o_outst, n);
    end
  endtask

  initial begin
    test_reset();
    test_slot();
    test_backpressure();
    test_cfg_depth();
    test_len_err();
    test_reset_mid();
    test_cfg_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
